// File: rtl/mem_pkg.sv
// Shared defaults and address helpers for the cache memory responder.
package mem_pkg;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_LATENCY   = 4;
   localparam int DEF_MEM_WORDS = 1024;

   // Byte address to word index; bit 0 dropped, upper bits masked off.
   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input int          words);
      return (addr >> 1) & 32'(words - 1);
   endfunction
endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response pipeline carrying {valid, addr, data}.
module mem_resp_pipe
   import mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              pending
);

   logic [LATENCY-1:0] vld;
   logic [ADDR_W-1:0]  addr_q [LATENCY];
   logic [DATA_W-1:0]  data_q [LATENCY];

   // Payload only moves with a valid beat, so the last stage holds its value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         if (in_valid) begin
            addr_q[0] <= in_addr;
            data_q[0] <= in_data;
         end
         for (int i = 1; i < LATENCY; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) begin
               addr_q[i] <= addr_q[i-1];
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_addr  = addr_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];
   assign pending   = |vld;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache fill / write-back traffic.
module cache_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int LATENCY   = DEF_LATENCY,
   parameter int MEM_WORDS = DEF_MEM_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_mem,
   input  logic [ADDR_W-1:0] read_address_mem,
   input  logic              write_mem,
   input  logic [ADDR_W-1:0] write_data_address,
   input  logic [DATA_W-1:0] write_data_mem,
   output logic              read_data_valid,
   output logic [DATA_W-1:0] read_data_mem,
   output logic [ADDR_W-1:0] read_data_addr,
   output logic              pending
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [DATA_W-1:0] storage [MEM_WORDS];
   logic [IDX_W-1:0]  ridx;
   logic [IDX_W-1:0]  widx;
   logic              wr_en;
   logic [DATA_W-1:0] rd_word;

   assign ridx  = IDX_W'(word_index(32'(read_address_mem), MEM_WORDS));
   assign widx  = IDX_W'(word_index(32'(write_data_address), MEM_WORDS));
   assign wr_en = write_mem & rst;

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         storage[widx] <= write_data_mem;
      end
   end

   // Write-first bypass for a same-index read in the same cycle.
   assign rd_word = (wr_en && (widx == ridx)) ? write_data_mem
                                              : storage[ridx];

   mem_resp_pipe #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LATENCY (LATENCY)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (read_mem),
      .in_addr   (read_address_mem),
      .in_data   (rd_word),
      .out_valid (read_data_valid),
      .out_addr  (read_data_addr),
      .out_data  (read_data_mem),
      .pending   (pending)
   );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder with directed vectors.
module tb_cache_mem_responder;
   localparam int LAT = 4;

   typedef struct {
      int          due;
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        read_mem;
   logic [15:0] read_address_mem;
   logic        write_mem;
   logic [15:0] write_data_address;
   logic [15:0] write_data_mem;
   logic        read_data_valid;
   logic [15:0] read_data_mem;
   logic [15:0] read_data_addr;
   logic        pending;

   int   cyc;
   int   checks;
   int   errors;
   exp_t q[$];

   cache_mem_responder #(
      .ADDR_W    (16),
      .DATA_W    (16),
      .LATENCY   (LAT),
      .MEM_WORDS (1024)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .read_mem           (read_mem),
      .read_address_mem   (read_address_mem),
      .write_mem          (write_mem),
      .write_data_address (write_data_address),
      .write_data_mem     (write_data_mem),
      .read_data_valid    (read_data_valid),
      .read_data_mem      (read_data_mem),
      .read_data_addr     (read_data_addr),
      .pending            (pending)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every response against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (rst && read_data_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", {16'h0, read_data_addr}, 32'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(e.due));
            chk("resp_data", {16'h0, read_data_mem}, {16'h0, e.data});
            chk("resp_addr", {16'h0, read_data_addr}, {16'h0, e.addr});
         end
      end else if (rst && q.size() > 0 && q[0].due < cyc) begin
         e = q.pop_front();
         chk("missing_resp", 32'(e.due), 32'hFFFF_FFFF);
      end
   end

   task automatic step(input logic rd, input logic [15:0] ra,
                       input logic [15:0] rexp, input logic wr,
                       input logic [15:0] wa, input logic [15:0] wd);
      read_mem           = rd;
      read_address_mem   = ra;
      write_mem          = wr;
      write_data_address = wa;
      write_data_mem     = wd;
      if (rd) q.push_back('{cyc + LAT, ra, rexp});
      @(posedge clk);
      #1;
      read_mem  = 0;
      write_mem = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_valid"}, 32'(read_data_valid), 0);
      chk({name, "_data"}, {16'h0, read_data_mem}, 0);
      chk({name, "_addr"}, {16'h0, read_data_addr}, 0);
      chk({name, "_pending"}, 32'(pending), 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 0;
      read_mem = 0;
      read_address_mem = 0;
      write_mem = 0;
      write_data_address = 0;
      write_data_mem = 0;

      repeat (3) begin
         @(negedge clk);
         chk_zero("reset");
      end
      rst = 1;
      @(posedge clk);
      #1;

      // write then read with a different low byte bit
      step(0, 0, 0, 1, 16'h0010, 16'h1234);
      step(1, 16'h0011, 16'h1234, 0, 0, 0);
      idle(2);

      // burst
      for (int i = 0; i < 8; i++)
         step(0, 0, 0, 1, 16'(16'h0020 + 2 * i), 16'(16'hA000 + i));
      for (int i = 0; i < 8; i++) begin
         step(1, 16'(16'h0020 + 2 * i), 16'(16'hA000 + i), 0, 0, 0);
         chk("burst_pending", 32'(pending), 1);
      end
      for (int k = 0; k < 4; k++) begin
         chk("drain_pending", 32'(pending), 1);
         idle(1);
      end
      chk("idle_pending", 32'(pending), 0);

      // collisions
      step(1, 16'h0040, 16'hBEEF, 1, 16'h0040, 16'hBEEF);
      step(1, 16'h0020, 16'hA000, 1, 16'h0060, 16'h7777);
      step(1, 16'h0060, 16'h7777, 0, 0, 0);
      step(0, 0, 0, 1, 16'h0050, 16'h1111);
      step(1, 16'h0050, 16'h1111, 0, 0, 0);
      step(0, 0, 0, 1, 16'h0050, 16'h2222);
      step(1, 16'h0050, 16'h2222, 0, 0, 0);

      // address wrap
      step(0, 0, 0, 1, 16'h0802, 16'h5A5A);
      step(1, 16'h0002, 16'h5A5A, 0, 0, 0);
      idle(LAT + 2);
      chk("queue_empty_1", 32'(q.size()), 0);

      // reset while a read is in flight; write during reset is ignored
      step(1, 16'h0010, 16'h1234, 0, 0, 0);
      idle(1);
      rst = 0;
      q.delete();
      write_mem = 1;
      write_data_address = 16'h0010;
      write_data_mem = 16'hDEAD;
      read_mem = 1;
      read_address_mem = 16'h0010;
      #1;
      chk_zero("midreset");
      @(posedge clk);
      #1;
      write_mem = 0;
      read_mem = 0;
      rst = 1;
      idle(LAT + 2);
      step(1, 16'h0010, 16'h1234, 0, 0, 0);
      idle(LAT + 2);
      chk("queue_empty_2", 32'(q.size()), 0);
      chk("final_pending", 32'(pending), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
